uart_tx_serializer: RTL and testbench

UART transmit serializer that sits directly downstream of the UART configuration block. It accepts parallel bytes over a valid/ready handshake and shifts them onto the serial line `tx`. Each frame is one start bit, 8 data bits LSB-first, an optional even/odd parity bit, and 1 or 2 stop bits. Parity and stop-bit settings come from the configuration block and are sampled once per frame.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_tx_serializer_if.sv | 22 ++
 rtl/uart_baud_tick.sv | 26 ++
 rtl/uart_tx_serializer.sv | 129 ++++++++++++
 tb/tb_uart_tx_serializer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, parity and stop-bit codes.
// Used by both the configuration block and the transmit serializer.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP
    } uart_state_e;

    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_EVEN = 2'b10;
    localparam logic [1:0] PARITY_ODD  = 2'b11;

    localparam logic STOP_1 = 1'b0;
    localparam logic STOP_2 = 1'b1;

    // The reserved code 2'b01 falls through to "no parity".
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PARITY_EVEN) || (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Byte handshake and configuration bundle between upstream and the TX serializer.
interface uart_tx_serializer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [1:0]            parity_mode;
    logic                  stop_bits;
    logic                  tx;
    logic                  busy;

    modport master (
        output tx_data, tx_valid, parity_mode, stop_bits,
        input  tx_ready, tx, busy
    );

    modport slave (
        input  tx_data, tx_valid, parity_mode, stop_bits,
        output tx_ready, tx, busy
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-time counter: pulses tick for one cycle at count CLKS_PER_BIT-1, then wraps.
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int unsigned      CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    assign tick = (r_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clear || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_serializer_if.slave  bus
);
    localparam int unsigned      IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    uart_state_e           r_state, w_state_d;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_d;
    logic [IDX_W-1:0]      r_bit_idx, w_bit_idx_d;
    logic                  r_par_en, w_par_en_d;
    logic                  r_par_bit, w_par_bit_d;
    logic                  r_stop2, w_stop2_d;
    logic                  r_stop_cnt, w_stop_cnt_d;
    logic                  r_tx, w_tx_d;
    logic                  r_ready, w_ready_d;
    logic                  r_busy;
    logic                  w_tick;
    logic                  w_clear;

    // Holding the counter clear while idle makes every frame start on a full bit time.
    assign w_clear = (r_state == S_IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(w_clear),
        .tick (w_tick)
    );

    always_comb begin
        w_state_d    = r_state;
        w_shift_d    = r_shift;
        w_bit_idx_d  = r_bit_idx;
        w_par_en_d   = r_par_en;
        w_par_bit_d  = r_par_bit;
        w_stop2_d    = r_stop2;
        w_stop_cnt_d = r_stop_cnt;

        unique case (r_state)
            S_IDLE: begin
                if (bus.tx_valid && r_ready) begin
                    w_shift_d    = bus.tx_data;
                    w_par_en_d   = parity_enabled(bus.parity_mode);
                    w_par_bit_d  = (^bus.tx_data) ^ (bus.parity_mode == PARITY_ODD);
                    w_stop2_d    = bus.stop_bits;
                    w_bit_idx_d  = '0;
                    w_stop_cnt_d = 1'b0;
                    w_state_d    = S_START;
                end
            end
            S_START: begin
                if (w_tick) w_state_d = S_DATA;
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_d   = r_shift >> 1;
                    w_bit_idx_d = r_bit_idx + 1'b1;
                    if (r_bit_idx == LAST_IDX) begin
                        w_bit_idx_d = '0;
                        w_state_d   = r_par_en ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) w_state_d = S_STOP;
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_stop2 == STOP_2 && !r_stop_cnt) begin
                        w_stop_cnt_d = 1'b1;
                    end else begin
                        w_stop_cnt_d = 1'b0;
                        w_state_d    = S_IDLE;
                    end
                end
            end
            default: w_state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered with no lag.
        unique case (w_state_d)
            S_START:  w_tx_d = 1'b0;
            S_DATA:   w_tx_d = w_shift_d[0];
            S_PARITY: w_tx_d = w_par_bit_d;
            default:  w_tx_d = 1'b1;
        endcase
        w_ready_d = (w_state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_stop2    <= STOP_1;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_shift    <= w_shift_d;
            r_bit_idx  <= w_bit_idx_d;
            r_par_en   <= w_par_en_d;
            r_par_bit  <= w_par_bit_d;
            r_stop2    <= w_stop2_d;
            r_stop_cnt <= w_stop_cnt_d;
            r_tx       <= w_tx_d;
            r_ready    <= w_ready_d;
            r_busy     <= ~w_ready_d;
        end
    end

    assign bus.tx       = r_tx;
    assign bus.tx_ready = r_ready;
    assign bus.busy     = r_busy;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: a frame-level model predicts tx/tx_ready/busy every cycle.
module tb_uart_tx_serializer;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_serializer_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_serializer #(
        .CLKS_PER_BIT(CPB),
        .DATA_WIDTH  (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    bit   exp_q[$];
    int   frame_lens[$];
    int   busy_run    = 0;
    int   idle_run    = 0;
    int   last_gap    = -1;
    logic e_tx, e_rdy;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit has_parity(input logic [1:0] pm);
        return (pm == 2'b10) || (pm == 2'b11);
    endfunction

    function automatic int frame_len(input logic [1:0] pm, input logic sb);
        return 1 + 8 + (has_parity(pm) ? 1 : 0) + (sb ? 2 : 1);
    endfunction

    // Frame as line levels in transmit order; bit 0 goes out first.
    function automatic logic [11:0] frame_bits(input logic [7:0] d, input logic [1:0] pm,
                                               input logic sb);
        logic [11:0] b;
        int ones = 0;
        int k;
        b    = '1;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b[i+1] = d[i];
            ones += int'(d[i]);
        end
        k = 9;
        if (has_parity(pm)) begin
            b[k] = (pm == 2'b11) ? (ones % 2 == 0) : (ones % 2 == 1);
            k++;
        end
        b[k] = 1'b1;
        if (sb) b[k+1] = 1'b1;
        return b;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            busy_run = 0;
            idle_run = 0;
            chk("rst_tx", bus.tx, 1);
            chk("rst_tx_ready", bus.tx_ready, 1);
            chk("rst_busy", bus.busy, 0);
        end else begin
            e_rdy = (exp_q.size() == 0);
            e_tx  = 1'b1;
            if (!e_rdy) e_tx = exp_q[0];
            chk("tx", bus.tx, e_tx);
            chk("tx_ready", bus.tx_ready, e_rdy);
            chk("busy", bus.busy, !e_rdy);

            if (bus.busy) begin
                if (busy_run == 0) last_gap = idle_run;
                busy_run++;
                idle_run = 0;
            end else begin
                if (busy_run > 0) frame_lens.push_back(busy_run);
                busy_run = 0;
                idle_run++;
            end

            if (e_rdy) begin
                if (bus.tx_valid) begin
                    logic [11:0] fb;
                    int          n;
                    fb = frame_bits(bus.tx_data, bus.parity_mode, bus.stop_bits);
                    n  = frame_len(bus.parity_mode, bus.stop_bits);
                    for (int k = 0; k < n; k++)
                        for (int c = 0; c < CPB; c++) exp_q.push_back(fb[k]);
                end
            end else begin
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic wait_accept();
        logic r;
        int   n = 0;
        forever begin
            @(negedge clk);
            r = bus.tx_ready;
            @(posedge clk);
            if (r) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        forever begin
            @(negedge clk);
            if (bus.tx_ready && exp_q.size() == 0) break;
            n++;
            if (n > 200) begin
                chk("idle_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] pm, input logic sb);
        bus.tx_data     = d;
        bus.parity_mode = pm;
        bus.stop_bits   = sb;
        bus.tx_valid    = 1'b1;
        wait_accept();
        bus.tx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int exp_lens[9] = '{40, 48, 44, 40, 40, 48, 40, 40, 40};

        bus.tx_valid    = 1'b0;
        bus.tx_data     = '0;
        bus.parity_mode = 2'b00;
        bus.stop_bits   = 1'b0;

        // Pin the model against hand-derived frames.
        chk("model_55_none", {22'd0, frame_bits(8'h55, 2'b00, 1'b0)[9:0]}, 32'h2AA);
        chk("model_a5_even_2stop", frame_bits(8'hA5, 2'b10, 1'b1), 32'hD4A);
        chk("model_a5_odd", frame_bits(8'hA5, 2'b11, 1'b0), 32'hF4A);
        chk("model_01_odd_2stop", frame_bits(8'h01, 2'b11, 1'b1), 32'hC02);
        chk("model_len_reserved", frame_len(2'b01, 1'b0), 10);
        chk("model_len_par_2stop", frame_len(2'b10, 1'b1), 12);

        #1 rst = 1'b0;
        #1;
        chk("async_rst_tx", bus.tx, 1);
        chk("async_rst_tx_ready", bus.tx_ready, 1);
        chk("async_rst_busy", bus.busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        send(8'h55, 2'b00, 1'b0);
        wait_idle();
        send(8'hA5, 2'b10, 1'b1);
        wait_idle();
        send(8'hA5, 2'b11, 1'b0);
        wait_idle();
        send(8'h5A, 2'b01, 1'b0);
        wait_idle();

        send(8'h0F, 2'b00, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        bus.parity_mode = 2'b11;
        bus.stop_bits   = 1'b1;
        wait_idle();
        send(8'h01, 2'b11, 1'b1);
        wait_idle();

        bus.tx_data     = 8'h11;
        bus.parity_mode = 2'b00;
        bus.stop_bits   = 1'b0;
        bus.tx_valid    = 1'b1;
        wait_accept();
        bus.tx_data = 8'h22;
        wait_accept();
        bus.tx_valid = 1'b0;
        wait_idle();
        chk("b2b_idle_gap", last_gap, 1);

        send(8'h77, 2'b00, 1'b0);
        repeat (12) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midframe_rst_tx", bus.tx, 1);
        chk("midframe_rst_tx_ready", bus.tx_ready, 1);
        chk("midframe_rst_busy", bus.busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send(8'h3C, 2'b00, 1'b0);
        wait_idle();

        chk("frame_count", frame_lens.size(), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < frame_lens.size()) chk($sformatf("frame_len_%0d", i), frame_lens[i],
                                           exp_lens[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
